ctrl_decode_q: RTL and testbench
================================

Name: ctrl_decode_q

Overview:
- Registered, buffered successor to the single-cycle control decoder.
- Accepts one opcode/funct pair per cycle over a valid/ready handshake and decodes it into the processor control bundle.
- Queues decoded bundles in a parameterised FIFO for the execute side.
- Tracks HALT and illegal-opcode conditions in a small state machine, so fetch can be throttled, flushed and stopped cleanly in the pipelined core.

Parameters:
- DEPTH, 2, FIFO entries (1..8); pointer width is clog2(DEPTH), minimum 1.
- ILLEGAL_MASK, 32'h0000_0000, bit i set marks opcode i as illegal.
- HALT_OP, 5'b00000, opcode that halts the core and requests a memory dump.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  opcode/funct present.
- in_ready  out  1  block accepts this cycle.
- opcode  in  5  instruction [15:11].
- funct  in  2  instruction [1:0].
- flush  in  1  discard all queued bundles.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  consumer takes head.
- out_ctrl  out  CTRL_W (15)  head bundle, packed {reg_dst[1:0], se_sel[2:0], reg_write, dmem_write, dmem_en, alu_src2, pc_src, pc_imm, mem_to_reg, dmem_dump, jump, funct_pass}.
- out_err  out  1  head bundle came from an illegal opcode.
- halted  out  1  state is HALTED.
- fault  out  1  state is FAULT (sticky).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-low.
- Reset (rst==0 at posedge):
  - FIFO empty; state RUN.
  - out_valid=0, out_ctrl=0, out_err=0, halted=0, fault=0.
  - in_ready=0 during the reset cycle, 1 on the first cycle after release.
- Decode: combinational package function decode_ctrl(opcode, funct), evaluated on input and registered into the FIFO. Nothing decoded is exposed combinationally.
- Accept rule: accept = in_valid & in_ready.
  - in_ready = (state==RUN) & ~full & ~flush.
  - in_ready has no combinational path from out_ready.
- Latency: accepted at edge N; visible at head with out_valid=1 from cycle N+1 when the FIFO was empty.
- Pop rule: pop = out_valid & out_ready.
  - out_ctrl/out_err hold stable while out_valid & ~out_ready.
- Simultaneous push+pop when not full and not empty: count unchanged, order preserved.
- Full: count==DEPTH gives in_ready=0. A pop that cycle frees a slot, but in_ready only reasserts the next cycle.
- Empty: out_valid=0; out_ctrl is don't-care but driven to 0.
- Pointers wrap modulo DEPTH; the full/empty distinction uses a separate count register (0..DEPTH).
- State machine:
  - RUN:
    - accepted opcode==HALT_OP: enqueue bundle with dmem_dump=1 and all write enables 0, then go to HALTED.
    - accepted opcode with ILLEGAL_MASK[opcode] set: enqueue bundle with reg_write=dmem_write=dmem_en=0 and err=1, then go to FAULT.
  - HALTED: in_ready=0; queued entries still drain; exit only via reset.
  - FAULT: in_ready=0; fault=1; queued entries drain; exit only via reset.
- Flush: empties the FIFO at the next edge (count=0, pointers=0) and overrides any pop that cycle. It does not change state.
- Simultaneous flush and in_valid: no accept, because in_ready is low.
- Reset mid-stream: all queued bundles are lost; state returns to RUN.

Optional Feature:
- Macro: CTRL_DECODE_PERF_EN.
- When defined:
  - adds output perf_accepted [31:0], counting accepts, and output perf_stall [31:0], counting cycles with in_valid & ~in_ready.
  - both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: the ports and logic are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - CTRL_W=15 and the field bit-position localparams.
  - the ctrl_bundle_t packed struct.
  - the state enum {RUN, HALTED, FAULT}.
  - function decode_ctrl(), the per-ISA control table.
- Sub-module ctrl_fifo: generic DEPTH×WIDTH synchronous FIFO with push/pop/flush/count, instantiated with WIDTH=CTRL_W+1.

Test Plan:
- Reset hold then release, DEPTH=2: in_ready=1 at cycle 1; send opcode 5'b10001 (LD) → out_ctrl.mem_to_reg=1, dmem_en=1, out_valid=1 at cycle 2.
- out_ready=0, send 3 valid opcodes → first 2 accepted, in_ready=0 after the second; raise out_ready → bundles emerge in order and in_ready reasserts one cycle after the first pop.
- Push and pop every cycle for 20 cycles with a count of 1 → no bubbles, count stays 1, pointers wrap correctly.
- Send 5'b00000 then 5'b11011 → HALT bundle has dmem_dump=1, halted=1 the next cycle, the second opcode is never accepted, in_ready stays 0 until rst=0.
- ILLEGAL_MASK=32'h0000_0008, send opcode 5'b00011 → out_err=1, reg_write=0, fault=1 (sticky); a flush empties the FIFO but fault remains 1.
- Fill the FIFO, assert flush together with out_ready → out_valid=0 the next cycle, no pop counted; with CTRL_DECODE_PERF_EN, perf_stall increments on every blocked in_valid cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, field positions and the per-opcode decode table
// for the buffered control decoder.
package ctrl_pkg;

    localparam int CTRL_W = 15;

    localparam int B_FUNCT_PASS = 0;
    localparam int B_JUMP       = 1;
    localparam int B_DMEM_DUMP  = 2;
    localparam int B_MEM_TO_REG = 3;
    localparam int B_PC_IMM     = 4;
    localparam int B_PC_SRC     = 5;
    localparam int B_ALU_SRC2   = 6;
    localparam int B_DMEM_EN    = 7;
    localparam int B_DMEM_WRITE = 8;
    localparam int B_REG_WRITE  = 9;
    localparam int B_SE_SEL     = 10;
    localparam int B_REG_DST    = 13;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [2:0] se_sel;
        logic       reg_write;
        logic       dmem_write;
        logic       dmem_en;
        logic       alu_src2;
        logic       pc_src;
        logic       pc_imm;
        logic       mem_to_reg;
        logic       dmem_dump;
        logic       jump;
        logic       funct_pass;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    function automatic ctrl_bundle_t decode_ctrl(
        input logic [4:0] opcode,
        input logic [1:0] funct
    );
        ctrl_bundle_t c;
        c = '0;
        unique case (1'b1)
            (opcode == 5'b00000): c.dmem_dump = 1'b1;
            (opcode[4:2] == 3'b010): begin
                c.reg_dst   = 2'b01;
                c.se_sel    = 3'b001;
                c.reg_write = 1'b1;
                c.alu_src2  = 1'b1;
            end
            (opcode == 5'b10000): begin
                c.se_sel     = 3'b001;
                c.dmem_write = 1'b1;
                c.dmem_en    = 1'b1;
                c.alu_src2   = 1'b1;
            end
            (opcode == 5'b10001): begin
                c.reg_dst    = 2'b01;
                c.se_sel     = 3'b001;
                c.reg_write  = 1'b1;
                c.dmem_en    = 1'b1;
                c.alu_src2   = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            (opcode == 5'b11010): begin
                // funct 2'b11 is reserved for shifts: no writeback
                c.reg_dst    = 2'b10;
                c.reg_write  = (funct != 2'b11);
                c.funct_pass = 1'b1;
            end
            (opcode == 5'b11011): begin
                c.reg_dst    = 2'b10;
                c.reg_write  = 1'b1;
                c.funct_pass = 1'b1;
            end
            (opcode[4:2] == 3'b011): begin
                c.se_sel = 3'b010;
                c.pc_src = 1'b1;
            end
            (opcode == 5'b00100): begin
                c.se_sel = 3'b100;
                c.pc_imm = 1'b1;
                c.jump   = 1'b1;
            end
            (opcode == 5'b00110): begin
                c.reg_dst   = 2'b11;
                c.se_sel    = 3'b100;
                c.reg_write = 1'b1;
                c.pc_imm    = 1'b1;
                c.jump      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode_q_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; full/empty are
// derived by the user from the exported occupancy count.
module ctrl_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 16,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push & (count != CW'(DEPTH)) & ~flush;
    assign do_pop  = pop & (count != '0) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ctrl_decode_q.sv
// Registered, queued control decoder with RUN/HALTED/FAULT tracking.
// Define CTRL_DECODE_PERF_EN to add saturating accept/stall counters.
module ctrl_decode_q
    import ctrl_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] ILLEGAL_MASK = 32'h0000_0000,
    parameter logic [4:0]  HALT_OP      = 5'b00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [1:0]        funct,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_err,
    output logic              halted,
    output logic              fault
`ifdef CTRL_DECODE_PERF_EN
   ,output logic [31:0]       perf_accepted,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = CTRL_W + 1;

    state_t        state;
    state_t        state_nx;
    ctrl_bundle_t  entry;
    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic          full;
    logic          accept;
    logic          pop;
    logic          is_halt;
    logic          is_ill;

    assign full    = (count == CW'(DEPTH));
    assign accept  = in_valid & in_ready;
    assign pop     = out_valid & out_ready;
    assign is_halt = (opcode == HALT_OP);
    assign is_ill  = ~is_halt & ILLEGAL_MASK[opcode];

    always_comb begin
        entry = decode_ctrl(opcode, funct);
        if (is_halt || is_ill) begin
            entry.reg_write  = 1'b0;
            entry.dmem_write = 1'b0;
            entry.dmem_en    = 1'b0;
        end
        if (is_halt) entry.dmem_dump = 1'b1;
    end

    ctrl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata ({is_ill, entry}),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == RUN && accept) begin
            if (is_halt)     state_nx = HALTED;
            else if (is_ill) state_nx = FAULT;
        end
    end

    // rst gates in_ready so nothing is accepted during the reset cycle
    always_comb begin
        in_ready  = rst & (state == RUN) & ~full & ~flush;
        halted    = (state == HALTED);
        fault     = (state == FAULT);
        out_valid = (count != '0);
        out_ctrl  = out_valid ? head[CTRL_W-1:0] : '0;
        out_err   = out_valid & head[CTRL_W];
    end

`ifdef CTRL_DECODE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_accepted <= '0;
            perf_stall    <= '0;
        end else begin
            if (accept && perf_accepted != '1)
                perf_accepted <= perf_accepted + 32'd1;
            if (in_valid && !in_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_decode_q.sv
// Randomised and directed bench for ctrl_decode_q against a queue-based
// reference model of decode, FIFO order and the run/halt/fault mode.
module tb_ctrl_decode_q;

    localparam int          DEPTH = 2;
    localparam logic [31:0] MASK  = 32'h0000_0008;

    localparam int FP = 0, JMP = 1, DUMP = 2, M2R = 3, PIMM = 4;
    localparam int PSRC = 5, A2 = 6, DEN = 7, DWR = 8, RW = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  opcode = '0;
    logic [1:0]  funct = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_ctrl;
    logic        out_err;
    logic        halted;
    logic        fault;
`ifdef CTRL_DECODE_PERF_EN
    logic [31:0] perf_accepted;
    logic [31:0] perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] mq [$];
    int          mode;
    logic [31:0] m_acc;
    logic [31:0] m_stall;

    logic [4:0] ops [14] = '{5'b00001, 5'b01000, 5'b01001, 5'b01010,
                             5'b01011, 5'b10000, 5'b10001, 5'b11010,
                             5'b11011, 5'b01100, 5'b01110, 5'b00100,
                             5'b00110, 5'b10101};

    always #5 clk = ~clk;

    ctrl_decode_q #(
        .DEPTH        (DEPTH),
        .ILLEGAL_MASK (MASK),
        .HALT_OP      (5'b00000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .funct         (funct),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctrl      (out_ctrl),
        .out_err       (out_err),
        .halted        (halted),
        .fault         (fault)
`ifdef CTRL_DECODE_PERF_EN
       ,.perf_accepted (perf_accepted),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] ref_decode(input logic [4:0] op,
                                               input logic [1:0] fn);
        logic [14:0] c;
        c = '0;
        case (op)
            5'b00000: c[DUMP] = 1'b1;
            5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
                c[14:13] = 2'b01; c[12:10] = 3'b001; c[RW] = 1'b1; c[A2] = 1'b1;
            end
            5'b10000: begin
                c[12:10] = 3'b001; c[DWR] = 1'b1; c[DEN] = 1'b1; c[A2] = 1'b1;
            end
            5'b10001: begin
                c[14:13] = 2'b01; c[12:10] = 3'b001; c[RW] = 1'b1;
                c[DEN] = 1'b1; c[A2] = 1'b1; c[M2R] = 1'b1;
            end
            5'b11010: begin
                c[14:13] = 2'b10; c[RW] = (fn != 2'b11); c[FP] = 1'b1;
            end
            5'b11011: begin
                c[14:13] = 2'b10; c[RW] = 1'b1; c[FP] = 1'b1;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                c[12:10] = 3'b010; c[PSRC] = 1'b1;
            end
            5'b00100: begin
                c[12:10] = 3'b100; c[PIMM] = 1'b1; c[JMP] = 1'b1;
            end
            5'b00110: begin
                c[14:13] = 2'b11; c[12:10] = 3'b100; c[RW] = 1'b1;
                c[PIMM] = 1'b1; c[JMP] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] ref_entry(input logic [4:0] op,
                                              input logic [1:0] fn);
        logic [14:0] c;
        c = ref_decode(op, fn);
        if (op == 5'b00000) begin
            c[RW] = 1'b0; c[DWR] = 1'b0; c[DEN] = 1'b0; c[DUMP] = 1'b1;
            return {1'b0, c};
        end
        if (MASK[op]) begin
            c[RW] = 1'b0; c[DWR] = 1'b0; c[DEN] = 1'b0;
            return {1'b1, c};
        end
        return {1'b0, c};
    endfunction

    // Drives one cycle, compares every output before the edge, then
    // advances the model; returns at posedge+1.
    task automatic cycle(input logic iv, input logic [4:0] op,
                         input logic [1:0] fn, input logic fl,
                         input logic ordy);
        logic        exp_rdy;
        logic        acc;
        logic [15:0] hd;
        logic [15:0] dropped;
        in_valid  = iv;
        opcode    = op;
        funct     = fn;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (mode == 0) && (mq.size() < DEPTH) && !fl;
        hd = (mq.size() != 0) ? mq[0] : 16'h0;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, mq.size() != 0);
        check("out_ctrl", out_ctrl, hd[14:0]);
        check("out_err", out_err, hd[15]);
        check("halted", halted, mode == 1);
        check("fault", fault, mode == 2);
`ifdef CTRL_DECODE_PERF_EN
        check("perf_accepted", perf_accepted, m_acc);
        check("perf_stall", perf_stall, m_stall);
`endif
        @(posedge clk);
        acc = iv && exp_rdy;
        if (fl) mq.delete();
        else begin
            if (mq.size() != 0 && ordy) dropped = mq.pop_front();
            if (acc) mq.push_back(ref_entry(op, fn));
        end
        if (acc && mode == 0) begin
            if (op == 5'b00000) mode = 1;
            else if (MASK[op]) mode = 2;
        end
        if (acc && m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 1;
        if (iv && !exp_rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            opcode   = ops[$urandom_range(0, 13)];
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        mq.delete();
        mode     = 0;
        m_acc    = 0;
        m_stall  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        int v;
        mode    = 0;
        m_acc   = 0;
        m_stall = 0;

        // load right after reset
        do_reset(2);
        cycle(1, 5'b10001, 2'b00, 0, 0);
        check("ld_valid", out_valid, 1);
        check("ld_mem_to_reg", out_ctrl[M2R], 1);
        check("ld_dmem_en", out_ctrl[DEN], 1);
        cycle(0, 5'b0, 2'b0, 0, 1);

        // fill with consumer stalled, then drain
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, ops[i + 1], 2'(i), 0, 0);
            if (i == 1) check("full_in_ready", in_ready, 0);
        end
        cycle(0, 5'b0, 2'b0, 0, 1);
        check("reready", in_ready, 1);
        cycle(0, 5'b0, 2'b0, 0, 1);
        cycle(0, 5'b0, 2'b0, 0, 1);

        // streaming at occupancy one
        do_reset(1);
        cycle(1, 5'b01000, 2'b00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, ops[$urandom_range(0, 13)], 2'($urandom_range(0, 3)), 0, 1);
            check("stream_valid", out_valid, 1);
        end

        // halt blocks everything after it
        do_reset(1);
        cycle(1, 5'b00000, 2'b00, 0, 0);
        check("halt_state", halted, 1);
        check("halt_dump", out_ctrl[DUMP], 1);
        check("halt_rw", out_ctrl[RW], 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 5'b11011, 2'b00, 0, 0);
            check("halt_block", in_ready, 0);
        end
        cycle(0, 5'b0, 2'b0, 0, 1);
        check("halt_drained", out_valid, 0);
        check("halt_sticky", halted, 1);

        // illegal opcode and sticky fault
        do_reset(1);
        cycle(1, 5'b00011, 2'b00, 0, 0);
        check("ill_err", out_err, 1);
        check("ill_rw", out_ctrl[RW], 0);
        check("ill_fault", fault, 1);
        cycle(0, 5'b0, 2'b0, 1, 0);
        check("ill_flushed", out_valid, 0);
        check("ill_fault_kept", fault, 1);

        // flush on a full queue wins over pop
        do_reset(1);
        cycle(1, 5'b01001, 2'b00, 0, 0);
        cycle(1, 5'b10000, 2'b00, 0, 0);
        cycle(1, 5'b11011, 2'b00, 1, 1);
        check("flush_empty", out_valid, 0);
        cycle(1, 5'b11011, 2'b01, 0, 0);

        // random traffic; each new round also resets mid-stream
        for (int r = 0; r < 6; r++) begin
            do_reset(1 + (r % 2));
            for (int i = 0; i < 60; i++) begin
                v = int'($urandom_range(0, 29));
                cycle($urandom_range(0, 9) < 7,
                      (v == 0) ? 5'b00000 : (v == 1) ? 5'b00011 : ops[v % 14],
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 9) < 6);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
